// File: rtl/cpu_pkg.sv
// Shared types and helpers for the Lab 3 CPU control path.
// Instruction-type codes are also produced by the opcode decoder.
package cpu_pkg;

   typedef enum logic [2:0] {
      R   = 3'b000,
      I   = 3'b001,
      U   = 3'b010,
      BAD = 3'b111
   } instr_type_e;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd7
   } ctrl_state_e;

   localparam logic [1:0] IMM_NONE = 2'b00;
   localparam logic [1:0] IMM_I    = 2'b01;
   localparam logic [1:0] IMM_U    = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_UIMM = 2'b01;

   // Wide enough for the largest legal fetch timeout (255).
   localparam int unsigned WDOG_W = 8;

   typedef struct packed {
      logic       imem_req;
      logic       pc_en;
      logic       alu_en;
      logic       alu_src_imm;
      logic [1:0] imm_sel;
      logic       reg_we;
      logic [1:0] wb_sel;
   } ctrl_out_t;

   function automatic logic [1:0] imm_for(instr_type_e ty);
      logic [1:0] sel;
      case (ty)
         I:       sel = IMM_I;
         U:       sel = IMM_U;
         default: sel = IMM_NONE;
      endcase
      return sel;
   endfunction

   // Moore output decode; ir_en is excluded because it also depends on imem_ack.
   function automatic ctrl_out_t decode_outputs(ctrl_state_e st, instr_type_e ty);
      ctrl_out_t o;
      o = '0;
      case (st)
         StFetch: o.imem_req = 1'b1;
         StExec: begin
            o.alu_en      = 1'b1;
            o.alu_src_imm = (ty == I);
            o.imm_sel     = imm_for(ty);
         end
         StWb: begin
            o.reg_we  = 1'b1;
            o.pc_en   = 1'b1;
            o.imm_sel = imm_for(ty);
            o.wb_sel  = (ty == U) ? WB_UIMM : WB_ALU;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles spent waiting for imem_ack and flags the last
// permitted cycle so the controller can trap on the next edge.
module fetch_watchdog
   import cpu_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(FETCH_TIMEOUT - 1);

   logic [WDOG_W-1:0] cnt_q;

   assign expired = (cnt_q == LIMIT);

   // Holds at the limit so the count can never wrap back into range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (inc && !expired) begin
         cnt_q <= cnt_q + WDOG_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/writeback sequencing,
// imem handshake, fetch-timeout and illegal-opcode traps, retire counter.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 16,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [2:0]       instr_type,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_en,
   output logic             pc_en,
   output logic             alu_en,
   output logic             alu_src_imm,
   output logic [1:0]       imm_sel,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state_o,
   output logic             illegal_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] retired
);

   ctrl_state_e      state_q, state_d;
   instr_type_e      type_q, type_d;
   ctrl_out_t        out_q;
   logic             illegal_q, timeout_q;
   logic [CNT_W-1:0] retired_q;

   logic wd_clear, wd_inc, wd_expired;
   logic set_illegal, set_timeout;

   fetch_watchdog #(
      .FETCH_TIMEOUT(FETCH_TIMEOUT)
   ) u_fetch_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .inc     (wd_inc),
      .expired (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      wd_clear    = 1'b0;
      wd_inc      = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         StIdle: begin
            if (run) begin
               state_d  = StFetch;
               wd_clear = 1'b1;
            end
         end
         StFetch: begin
            // An ack on the last permitted cycle still wins over the timeout.
            if (imem_ack) begin
               state_d = StDecode;
            end else if (wd_expired) begin
               state_d     = StTrap;
               set_timeout = 1'b1;
            end else begin
               wd_inc = 1'b1;
            end
         end
         StDecode: begin
            type_d = instr_type_e'(instr_type);
            case (type_d)
               R, I, U: state_d = StExec;
               default: begin
                  state_d     = StTrap;
                  set_illegal = 1'b1;
               end
            endcase
         end
         StExec: state_d = StWb;
         StWb: begin
            if (run) begin
               state_d  = StFetch;
               wd_clear = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StTrap:  state_d = StTrap;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state, so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         type_q    <= R;
         out_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         out_q   <= decode_outputs(state_d, type_d);
         if (set_illegal) begin
            illegal_q <= 1'b1;
         end
         if (set_timeout) begin
            timeout_q <= 1'b1;
         end
         if (state_q == StWb) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   assign ir_en       = (state_q == StFetch) && imem_ack;
   assign imem_req    = out_q.imem_req;
   assign pc_en       = out_q.pc_en;
   assign alu_en      = out_q.alu_en;
   assign alu_src_imm = out_q.alu_src_imm;
   assign imm_sel     = out_q.imm_sel;
   assign reg_we      = out_q.reg_we;
   assign wb_sel      = out_q.wb_sel;
   assign state_o     = state_q;
   assign illegal_o   = illegal_q;
   assign timeout_o   = timeout_q;
   assign retired     = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the Lab 3 CPU. It sequences each instruction through fetch, decode, execute and writeback. It consumes the 3-bit instruction-type code from the opcode decoder and drives the datapath enables and muxes. It also owns the instruction-memory request handshake, fetch-timeout and illegal-opcode trapping, and a retired-instruction counter.

Parameters:
FETCH_TIMEOUT, 16, cycles FETCH waits for imem_ack before trapping; legal range 2..255.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; 1 = execute instructions, 0 = park in IDLE after current instruction
instr_type  in  3  decoder output for the current IR: 000 R, 001 I, 010 U, 111 illegal
imem_req  out  1  instruction-memory read request
imem_ack  in  1  instruction-memory data valid
ir_en  out  1  load instruction register
pc_en  out  1  advance PC
alu_en  out  1  ALU operand/result register enable
alu_src_imm  out  1  ALU operand B: 0 = rs2, 1 = immediate
imm_sel  out  2  00 none, 01 I-immediate, 10 U-immediate
reg_we  out  1  register-file write enable
wb_sel  out  2  00 ALU result, 01 U-immediate (lui)
state_o  out  3  current state: IDLE 0, FETCH 1, DECODE 2, EXEC 3, WB 4, TRAP 7
illegal_o  out  1  sticky: trapped on illegal opcode
timeout_o  out  1  sticky: trapped on fetch timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0, including retired, illegal_o, timeout_o, type_q and the wait counter. Reset is honoured mid-instruction and from TRAP.
- Outputs are Moore (decoded from state and type_q), except ir_en, which is 1 only in a FETCH cycle with imem_ack=1.
- IDLE: no enables asserted. If run=1, go to FETCH next cycle.
- FETCH: imem_req=1. The wait counter clears on FETCH entry and increments each cycle without ack.
  - imem_ack=1: ir_en=1, go to DECODE.
  - No ack and wait count = FETCH_TIMEOUT-1: go to TRAP, set timeout_o.
  - ack and timeout in the same cycle: ack wins.
- DECODE: sample instr_type into type_q.
  - 111 (or any undefined code): go to TRAP, set illegal_o.
  - Otherwise: go to EXEC.
- EXEC: alu_en=1. alu_src_imm=1 for I, else 0. imm_sel = 00 for R, 01 for I, 10 for U. Go to WB.
- WB: reg_we=1, pc_en=1, retired += 1. wb_sel = 01 for U, 00 for R/I; imm_sel held as in EXEC. Next state is FETCH if run=1, else IDLE.
- TRAP: all enables 0, imem_req=0. Flags hold. Exit only by rst.
- run deassertion takes effect only at the WB decision; an in-flight instruction always completes.
- imem_ack outside FETCH is ignored.
- retired wraps modulo 2^CNT_W with no flag.
- Latency: minimum 4 cycles per instruction (ack in first FETCH cycle). Each missing ack adds one cycle.

Decomposition:
- Package cpu_pkg:
  - instr_type_e: R=3'b000, I=3'b001, U=3'b010, BAD=3'b111.
  - ctrl_state_e: encodings as state_o.
  - imm_sel constants: IMM_NONE, IMM_I, IMM_U.
  - wb_sel constants: WB_ALU, WB_UIMM.
  - The opcode decoder shares instr_type_e.
- One sub-module: fetch_watchdog. It provides the wait counter with clear/inc inputs and an expired output at FETCH_TIMEOUT-1.
- The opcode decoder stays outside this block; instr_type is an input.

Test Plan:
- Reset, then run=1, imem_ack=1 on the first FETCH cycle, instr_type=000 -> state_o 0,1,2,3,4,1. ir_en pulse in cycle 1, alu_src_imm=0, reg_we=1 and pc_en=1 in WB, wb_sel=00, retired=1.
- I-type, ack delayed 3 cycles -> FETCH lasts 4 cycles, imem_req high throughout, ir_en only on the ack cycle. EXEC shows alu_src_imm=1, imm_sel=01; retired increments by 1.
- U-type -> EXEC imm_sel=10; WB shows wb_sel=01, reg_we=1. Three back-to-back U instructions with run=1 -> retired=3 after 12 cycles.
- instr_type=111 in DECODE -> state_o=7 next cycle, illegal_o=1, no reg_we/pc_en pulse, retired unchanged. Holds for 20 cycles; rst returns state_o to 0 with all flags 0.
- FETCH_TIMEOUT=16, imem_ack held 0 -> TRAP exactly 16 cycles after FETCH entry, timeout_o=1. Repeat with ack arriving on cycle 16 -> goes to DECODE, no trap.
- run dropped during EXEC -> WB completes (retired+1), then IDLE. Assert rst during EXEC -> immediate IDLE, outputs 0. Preload retired=2^32-1 -> wraps to 0.
